// File: rtl/mul_seq_16_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_16_if
//  Description : Bundle for the sequential multiplier. It carries the
//                start/busy/done handshake to the control FSM, the operands
//                and product, and the link to the shared adder stage.
//                slave  = multiplier side
//                master = control FSM + adder stage side
//  Signals     : start, a, b, busy, done, p,
//                add_a, add_b, add_cin, add_s, add_c,
//                sgn (only when MUL_SIGNED_EN is defined)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_seq_16_if #(
    parameter int WIDTH = 16
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_s;
    logic               add_c;

`ifdef MUL_SIGNED_EN
    logic               sgn;

    modport slave (
        input  start, a, b, sgn, add_s, add_c,
        output busy, done, p, add_a, add_b, add_cin
    );

    modport master (
        output start, a, b, sgn, add_s, add_c,
        input  busy, done, p, add_a, add_b, add_cin
    );
`else
    modport slave (
        input  start, a, b, add_s, add_c,
        output busy, done, p, add_a, add_b, add_cin
    );

    modport master (
        output start, a, b, add_s, add_c,
        input  busy, done, p, add_a, add_b, add_cin
    );
`endif

endinterface
`default_nettype wire

// File: rtl/mul_seq_16.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_16
//  Description : Sequential WIDTH x WIDTH shift-add multiplier. One partial
//                product add per iteration is performed on the shared
//                external adder stage (add_a/add_b/add_cin out,
//                add_s/add_c back after ADD_LAT cycles).
//  Ports       : clk      - system clock, rising edge
//                rst      - synchronous active-high reset
//                bus      - mul_seq_16_if.slave
//                  start  in   request, sampled only in IDLE
//                  a, b   in   multiplicand / multiplier
//                  busy   out  operation in progress
//                  done   out  one-cycle pulse, product valid
//                  p      out  2*WIDTH product, held until next start
//                  add_*  adder stage operands / results
//                  sgn    in   two's complement mode (MUL_SIGNED_EN only)
//  Parameters  : WIDTH    operand width (iterations = WIDTH)
//                ADD_LAT  adder latency in cycles, 1..4
//  Options     : MUL_SIGNED_EN - adds the sgn input and a NEG state that
//                conditionally negates the product (+1 cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_16 #(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    mul_seq_16_if.slave bus
);

    localparam int                 c_CNT_W     = $clog2(WIDTH + 1);
    localparam int                 c_PW        = 2 * WIDTH;
    localparam logic [c_CNT_W-1:0] c_ITER_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_ITER_LAST = c_CNT_W'(WIDTH);
    // WAIT spans ADD_LAT-1 cycles; the counter runs 0 .. ADD_LAT-2.
    localparam logic [2:0]         c_WAIT_LAST = 3'((ADD_LAT > 1) ? (ADD_LAT - 2) : 0);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_ISSUE = 3'd1;
    localparam logic [2:0] c_S_WAIT  = 3'd2;
    localparam logic [2:0] c_S_SHIFT = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;
`ifdef MUL_SIGNED_EN
    localparam logic [2:0] c_S_NEG   = 3'd5;
    localparam logic [2:0] c_S_AFTER = c_S_NEG;
    localparam logic [c_PW-1:0]  c_ONE_P = c_PW'(1);
    localparam logic [WIDTH-1:0] c_ONE_W = WIDTH'(1);
`else
    localparam logic [2:0] c_S_AFTER = c_S_DONE;
`endif

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [c_CNT_W-1:0] r_iter;
    logic [c_CNT_W-1:0] w_iter_inc;
    logic [2:0]         r_wcnt;
    logic [WIDTH-1:0]   r_add_a;
    logic [WIDTH-1:0]   r_add_b;
    logic [c_PW-1:0]    r_p;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [c_PW-1:0]    w_shifted;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

`ifdef MUL_SIGNED_EN
    logic               r_sign;
    logic               w_sign;
    logic [c_PW-1:0]    w_acc_neg;

    // In signed mode the loop always runs on magnitudes; 0x8000 negates
    // to itself, which is the correct unsigned magnitude of -32768.
    assign w_a_mag   = (bus.sgn && bus.a[WIDTH-1]) ? (~bus.a + c_ONE_W) : bus.a;
    assign w_b_mag   = (bus.sgn && bus.b[WIDTH-1]) ? (~bus.b + c_ONE_W) : bus.b;
    assign w_sign    = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    assign w_acc_neg = ~{r_acc_hi, r_acc_lo} + c_ONE_P;
`else
    assign w_a_mag   = bus.a;
    assign w_b_mag   = bus.b;
`endif

    // 33-bit right shift of {carry, sum, acc_lo}; dropping acc_lo[0]
    // retires the multiplier bit that was just consumed.
    assign w_shifted  = {bus.add_c, bus.add_s, r_acc_lo[WIDTH-1:1]};
    assign w_iter_inc = r_iter + c_ITER_ONE;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = c_S_ISSUE;
                end
            end
            c_S_ISSUE: begin
                w_state_nxt = (ADD_LAT > 1) ? c_S_WAIT : c_S_SHIFT;
            end
            c_S_WAIT: begin
                if (r_wcnt == c_WAIT_LAST) begin
                    w_state_nxt = c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                w_state_nxt = (w_iter_inc == c_ITER_LAST) ? c_S_AFTER : c_S_ISSUE;
            end
`ifdef MUL_SIGNED_EN
            c_S_NEG: begin
                w_state_nxt = c_S_DONE;
            end
`endif
            c_S_DONE: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (next values of the registered handshake outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_accept   = 1'b0;
        w_busy_nxt = r_busy;
        w_done_nxt = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_accept   = bus.start;
                w_busy_nxt = bus.start;
            end
            c_S_DONE: begin
                // busy drops in the same cycle that done rises
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_iter   <= '0;
            r_wcnt   <= '0;
            r_add_a  <= '0;
            r_add_b  <= '0;
            r_p      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef MUL_SIGNED_EN
            r_sign   <= 1'b0;
`endif
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= w_a_mag;
                        r_acc_hi <= '0;
                        r_acc_lo <= w_b_mag;
                        r_iter   <= '0;
                        // Operands are registered on ISSUE entry so they
                        // are already stable during the ISSUE cycle.
                        r_add_a  <= '0;
                        r_add_b  <= w_b_mag[0] ? w_a_mag : '0;
`ifdef MUL_SIGNED_EN
                        r_sign   <= w_sign;
`endif
                    end
                end
                c_S_ISSUE: begin
                    r_wcnt <= '0;
                end
                c_S_WAIT: begin
                    r_wcnt <= r_wcnt + 3'd1;
                end
                c_S_SHIFT: begin
                    {r_acc_hi, r_acc_lo} <= w_shifted;
                    r_iter               <= w_iter_inc;
                    // Preload the next iteration's operands; after the last
                    // iteration they keep their final values.
                    if (w_state_nxt == c_S_ISSUE) begin
                        r_add_a <= w_shifted[c_PW-1:WIDTH];
                        r_add_b <= w_shifted[0] ? r_mcand : '0;
                    end
                end
`ifdef MUL_SIGNED_EN
                c_S_NEG: begin
                    if (r_sign) begin
                        {r_acc_hi, r_acc_lo} <= w_acc_neg;
                    end
                end
`endif
                c_S_DONE: begin
                    r_p <= {r_acc_hi, r_acc_lo};
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.p       = r_p;
    assign bus.add_a   = r_add_a;
    assign bus.add_b   = r_add_b;
    assign bus.add_cin = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_seq_16
//  Description : Self-checking bench for mul_seq_16. Two instances are run:
//                ADD_LAT=1 (index 0) and ADD_LAT=3 (index 1), each with its
//                own delayed-adder model. A behavioural model predicts the
//                handshake timing, the product and the per-iteration adder
//                operands; literal expectations pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_16;

    localparam int W = 16;
`ifdef MUL_SIGNED_EN
    localparam int c_XTRA = 1;
`else
    localparam int c_XTRA = 0;
`endif
    localparam int c_LAT1 = W * 2 + 1 + c_XTRA;
    localparam int c_LAT3 = W * 4 + 1 + c_XTRA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mul_seq_16_if #(.WIDTH(W)) m1 ();
    mul_seq_16_if #(.WIDTH(W)) m3 ();

    mul_seq_16 #(.WIDTH(W), .ADD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(m1));
    mul_seq_16 #(.WIDTH(W), .ADD_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(m3));

    // Stimulus registers
    logic        st_i [2];
    logic [15:0] a_i  [2];
    logic [15:0] b_i  [2];
    assign m1.start = st_i[0];
    assign m1.a     = a_i[0];
    assign m1.b     = b_i[0];
    assign m3.start = st_i[1];
    assign m3.a     = a_i[1];
    assign m3.b     = b_i[1];
`ifdef MUL_SIGNED_EN
    logic s_i [2];
    assign m1.sgn = s_i[0];
    assign m3.sgn = s_i[1];
`endif

    // Adder stage models: plain 17-bit add, delayed by the configured latency
    logic [W:0] pipe1;
    logic [W:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1    <= {1'b0, m1.add_a} + {1'b0, m1.add_b} + {{W{1'b0}}, m1.add_cin};
        pipe3[0] <= {1'b0, m3.add_a} + {1'b0, m3.add_b} + {{W{1'b0}}, m3.add_cin};
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign m1.add_s = pipe1[W-1:0];
    assign m1.add_c = pipe1[W];
    assign m3.add_s = pipe3[2][W-1:0];
    assign m3.add_c = pipe3[2][W];

    // Observed outputs, indexed by instance
    logic [31:0] p_o    [2];
    logic        busy_o [2];
    logic        done_o [2];
    logic [15:0] adda_o [2];
    logic [15:0] addb_o [2];
    logic        cin_o  [2];
    assign p_o[0]    = m1.p;     assign p_o[1]    = m3.p;
    assign busy_o[0] = m1.busy;  assign busy_o[1] = m3.busy;
    assign done_o[0] = m1.done;  assign done_o[1] = m3.done;
    assign adda_o[0] = m1.add_a; assign adda_o[1] = m3.add_a;
    assign addb_o[0] = m1.add_b; assign addb_o[1] = m3.add_b;
    assign cin_o[0]  = m1.add_cin; assign cin_o[1] = m3.add_cin;

    // Model state
    logic        armed = 1'b0;
    logic        in_op  [2] = '{1'b0, 1'b0};
    int          t0     [2] = '{0, 0};
    logic [31:0] hold_p [2] = '{32'd0, 32'd0};
    logic [31:0] new_p  [2] = '{32'd0, 32'd0};
    logic [15:0] ma     [2] = '{16'd0, 16'd0};
    logic [15:0] mb     [2] = '{16'd0, 16'd0};

    function automatic int lat_of(input int d);
        return (d == 0) ? c_LAT1 : c_LAT3;
    endfunction

    function automatic int per_of(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_op[0]  = 1'b0;
        in_op[1]  = 1'b0;
        hold_p[0] = 32'd0;
        hold_p[1] = 32'd0;
    endtask

    // Compare process: every cycle, every instance
    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                int          k;
                int          i;
                logic        be;
                logic        de;
                logic [63:0] part;
                be = 1'b0;
                de = 1'b0;
                if (in_op[d]) begin
                    k = cyc - t0[d];
                    if (k < lat_of(d)) begin
                        be = 1'b1;
                    end else begin
                        de        = 1'b1;
                        hold_p[d] = new_p[d];
                        in_op[d]  = 1'b0;
                    end
                    if (k < W * per_of(d)) begin
                        i    = k / per_of(d);
                        part = 64'(ma[d]) * (64'(mb[d]) & ((64'd1 << i) - 64'd1));
                        chk("add_a", adda_o[d], part >> i);
                        chk("add_b", addb_o[d], mb[d][i] ? ma[d] : 16'd0);
                    end
                end
                chk("busy", busy_o[d], be);
                chk("done", done_o[d], de);
                chk("p", p_o[d], hold_p[d]);
                chk("add_cin", cin_o[d], 1'b0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        armed = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy_o[d], 1'b0);
            chk("rst_done", done_o[d], 1'b0);
            chk("rst_p", p_o[d], 32'd0);
        end
    endtask

    // One operation on instance d. glitch_k / rst_k (cycles after the
    // start-sampling edge) inject an ignored start or a reset; 0 = none.
    task automatic op(input int d, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input int glitch_k, input int rst_k,
                      input logic [31:0] lit_p, input int lit_k);
        int kd;
        kd = -1;
        @(negedge clk);
        st_i[d] = 1'b1;
        a_i[d]  = a;
        b_i[d]  = b;
`ifdef MUL_SIGNED_EN
        s_i[d]  = s;
`endif
        @(posedge clk);
        #1;
        t0[d] = cyc;
        if (s) begin
            new_p[d] = 32'(int'($signed(a)) * int'($signed(b)));
            ma[d]    = a[15] ? 16'(-int'($signed(a))) : a;
            mb[d]    = b[15] ? 16'(-int'($signed(b))) : b;
        end else begin
            new_p[d] = {16'd0, a} * {16'd0, b};
            ma[d]    = a;
            mb[d]    = b;
        end
        in_op[d] = 1'b1;
        for (int k = 0; k <= lat_of(d); k++) begin
            @(negedge clk);
            if (k == glitch_k && k != 0) begin
                st_i[d] = 1'b1;
                a_i[d]  = 16'd1;
                b_i[d]  = 16'd1;
            end else begin
                st_i[d] = 1'b0;
                a_i[d]  = ~a;
                b_i[d]  = ~b;
            end
            if (done_o[d] && kd < 0) kd = k;
            if (k == rst_k && k != 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                model_reset();
                @(negedge clk);
                rst = 1'b0;
                chk("midrst_busy", busy_o[d], 1'b0);
                chk("midrst_done", done_o[d], 1'b0);
                chk("midrst_p", p_o[d], 32'd0);
                return;
            end
        end
        chk("done_cycle", 64'(kd), 64'(lit_k));
        chk("p_literal", p_o[d], lit_p);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            st_i[d] = 1'b0;
            a_i[d]  = 16'd0;
            b_i[d]  = 16'd0;
`ifdef MUL_SIGNED_EN
            s_i[d]  = 1'b0;
`endif
        end
        repeat (2) @(posedge clk);
        do_reset();

        op(0, 16'd8,    16'd80,   1'b0, 0,  0,  32'h0000_0280, 33 + c_XTRA);
        op(0, 16'd208,  16'd308,  1'b0, 0,  0,  32'h0000_FA40, 33 + c_XTRA);
        op(0, 16'hFFFF, 16'hFFFF, 1'b0, 0,  0,  32'hFFFE_0001, 33 + c_XTRA);
        op(0, 16'h0000, 16'h1234, 1'b0, 0,  0,  32'h0000_0000, 33 + c_XTRA);
        op(0, 16'd80,   16'd80,   1'b0, 10, 0,  32'h0000_1900, 33 + c_XTRA);
        op(0, 16'd5,    16'd7,    1'b0, 0,  15, 32'h0000_0000, 33 + c_XTRA);
        op(0, 16'h1234, 16'h0000, 1'b0, 0,  0,  32'h0000_0000, 33 + c_XTRA);
        op(1, 16'h1234, 16'h0056, 1'b0, 0,  0,  32'h0006_1D78, 65 + c_XTRA);
        op(1, 16'hFFFF, 16'hFFFF, 1'b0, 0,  0,  32'hFFFE_0001, 65 + c_XTRA);
`ifdef MUL_SIGNED_EN
        op(0, 16'hFFFD, 16'd5,    1'b1, 0,  0,  32'hFFFF_FFF1, 34);
        op(0, 16'hFFFD, 16'd5,    1'b0, 0,  0,  32'h0004_FFF1, 34);
        op(0, 16'h8000, 16'h8000, 1'b1, 0,  0,  32'h4000_0000, 34);
        op(1, 16'd7,    16'hFFFE, 1'b1, 0,  0,  32'hFFFF_FFF2, 66);
`endif
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_seq_16.md
Name: mul_seq_16

Overview:
- Sequential 16x16 shift-add multiplier for the multicycle datapath.
- Sits directly upstream and downstream of the shared 16-bit adder stage: drives its operand/carry-in inputs and consumes its sum/carry outputs, one partial-product add per iteration.
- Presents a start/busy/done handshake to the control FSM and returns a 32-bit product.

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH; iteration count = WIDTH.
- ADD_LAT, 1, clock cycles from adder operands being driven to a valid s/c; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  multiplicand; latched on accepted start.
- b  in  WIDTH  multiplier; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; product valid.
- p  out  2*WIDTH  product; held until the next accepted start.
- add_a  out  WIDTH  adder operand A (accumulator high half).
- add_b  out  WIDTH  adder operand B (multiplicand or 0).
- add_cin  out  1  adder carry-in; always 0.
- add_s  in  WIDTH  adder sum.
- add_c  in  1  adder carry-out.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, p=0, add_a=0, add_b=0, add_cin=0; iteration counter=0, wait counter=0. Reset overrides every state, including mid-operation; any partial product is discarded.
- States: IDLE, ISSUE, WAIT, SHIFT, DONE.
- IDLE: start=1 latches mcand=a and mplr=b, clears acc_hi and sets acc_lo=b, clears the iteration count, then goes to ISSUE with busy=1.
- ISSUE:
  - drive add_a=acc_hi, add_b = acc_lo[0] ? mcand : 0.
  - go to WAIT if ADD_LAT>1, else to SHIFT.
- WAIT: hold operands for ADD_LAT-1 cycles, then go to SHIFT.
- SHIFT:
  - capture {add_c, add_s}; {acc_hi, acc_lo} <= {add_c, add_s, acc_lo} >> 1, i.e. a 33-bit right shift so the carry is kept.
  - increment the iteration count.
  - count==WIDTH goes to DONE, otherwise back to ISSUE.
- Operand stability: add_a/add_b are stable from ISSUE entry through the SHIFT capture cycle.
- DONE:
  - p <= {acc_hi, acc_lo}; done=1 for exactly one cycle; busy=0.
  - next state IDLE. The DONE-to-IDLE transition does not accept a start in the same cycle.
- Latency:
  - iteration = ADD_LAT+1 cycles.
  - done asserted WIDTH*(ADD_LAT+1)+1 cycles after the start-sampling edge; 33 cycles for defaults.
  - latency is fixed, independent of operand values.
- start while busy=1: ignored, no queuing; latched operands unchanged.
- a or b = 0: full iteration count still executed; p=0.
- Maximum operands: 0xFFFF*0xFFFF; the carry path must yield 0xFFFE0001 with no truncation.
- In IDLE, add_a/add_b hold their last values; the adder output is ignored outside SHIFT.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined:
  - extra input port sgn (1 bit), sampled with start.
  - sgn=1 treats a and b as two's complement: magnitudes are latched and sign = a[15]^b[15].
  - an extra NEG state between the final SHIFT and DONE negates the 32-bit product when sign=1.
  - NEG is always traversed, so latency is +1 cycle regardless of sgn.
- Undefined: no sgn port, no NEG state; unsigned only; latency as above.
- -32768 magnitude is handled as unsigned 0x8000.

Test Plan:
- a=8, b=80, start pulse, ADD_LAT=1 -> done pulse exactly 33 cycles later, p=0x00000280, busy low afterwards.
- a=208, b=308 -> p=0x0000FA40; add_b observed toggling between 0 and 0x00D0 per the multiplier bits.
- a=0xFFFF, b=0xFFFF -> p=0xFFFE0001 (carry capture check); then a=0, b=0x1234 -> p=0 with the same latency.
- Start a=80, b=80; pulse start with a=1, b=1 at cycle 10 -> ignored, p=0x00001900; rst asserted at cycle 15 of a new operation -> next cycle busy=0, done=0, p=0.
- ADD_LAT=3 bench (adder model delayed 3 cycles), a=0x1234, b=0x0056 -> done at cycle 65, p=0x00061D78.
- MUL_SIGNED_EN defined, sgn=1, a=0xFFFD, b=5 -> p=0xFFFFFFF1 at cycle 34; sgn=0, same operands -> p=0x0004FFF1.
